// File: rtl/pet_pkg.sv
// pet_pkg: shared stat/action indices, per-action delta table and saturating stat arithmetic
package pet_pkg;
    localparam int N_STATS = 6;
    localparam int N_ACTS = 6;
    localparam int STAT_MAX = 15;
    typedef logic [3:0] stat_t;
    typedef logic signed [5:0] delta_t;
    localparam int S_HUNGER = 0;
    localparam int S_HAPPINESS = 1;
    localparam int S_HEALTH = 2;
    localparam int S_HYGIENE = 3;
    localparam int S_ENERGY = 4;
    localparam int S_SOCIAL = 5;
    localparam int A_FEED = 0;
    localparam int A_PLAY = 1;
    localparam int A_CLEAN = 2;
    localparam int A_SLEEP = 3;
    localparam int A_MEDICINE = 4;
    localparam int A_PET = 5;
    // rows by action, columns by stat; clean's hygiene set-to-max is handled separately
    localparam delta_t [0:N_ACTS-1][0:N_STATS-1] ACT_DELTA = '{
        '{6'sd4, 6'sd0, 6'sd0, 6'sd0, 6'sd0, 6'sd0},
        '{6'sd0, 6'sd3, 6'sd0, 6'sd0, -6'sd2, 6'sd1},
        '{6'sd0, 6'sd0, 6'sd0, 6'sd0, 6'sd0, 6'sd0},
        '{6'sd0, 6'sd0, 6'sd0, 6'sd0, 6'sd5, 6'sd0},
        '{6'sd0, -6'sd1, 6'sd4, 6'sd0, 6'sd0, 6'sd0},
        '{6'sd0, 6'sd1, 6'sd0, 6'sd0, 6'sd0, 6'sd3}
    };

    function automatic logic [N_STATS-1:0] rand_dec(logic [4:0] r);
        return {r[4], r[3], r[2], 1'b0, r[1], r[0]};
    endfunction

    function automatic stat_t apply(stat_t old, delta_t ad, delta_t td, logic set_max);
        delta_t s;
        s = (set_max ? 6'sd15 : $signed({2'b00, old})) + ad + td;
        return s < 6'sd0 ? '0 : s > 6'sd15 ? 4'(STAT_MAX) : s[3:0];
    endfunction
endpackage

// File: rtl/pet_stats_tracker_if.sv
// pet_stats_tracker_if: control inputs and registered wellbeing outputs of the pet tracker
interface pet_stats_tracker_if;
    import pet_pkg::*;
    logic ena;
    logic [7:0] action_in;
    logic [31:0] rand_in;
    stat_t hunger;
    stat_t happiness;
    stat_t health;
    stat_t hygiene;
    stat_t energy;
    stat_t social;
    logic stat_valid;
    logic [3:0] action_ack;
    modport master (
        output ena, action_in, rand_in,
        input hunger, happiness, health, hygiene, energy, social, stat_valid, action_ack
    );
    modport slave (
        input ena, action_in, rand_in,
        output hunger, happiness, health, hygiene, energy, social, stat_valid, action_ack
    );
endinterface

// File: rtl/pet_tick_gen.sv
// pet_tick_gen: enabled free-running counter whose wrap cycle is the decay tick
module pet_tick_gen #(
    parameter logic [23:0] TICK_COUNT = 24'd10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    output logic tick
);
    logic [23:0] cnt;
    assign tick = ena && cnt == TICK_COUNT - 24'd1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (ena) cnt <= tick ? '0 : cnt + 24'd1;
    end
endmodule

// File: rtl/pet_stats_tracker.sv
// pet_stats_tracker: debounced button actions plus random decay ticks update six saturating 4-bit stats
module pet_stats_tracker
    import pet_pkg::*;
#(
    parameter logic [23:0] TICK_COUNT = 24'd10_000_000,
    parameter int COOLDOWN = 8,
    parameter stat_t INIT_LEVEL = 4'd8
) (
    input logic clk,
    input logic rst_n,
    pet_stats_tracker_if.slave bus
);
    localparam int CW = COOLDOWN > 1 ? $clog2(COOLDOWN + 1) : 1;
    logic [5:0] s1, s2, prv, edg;
    logic [2:0] prime;
    logic [CW-1:0] cd;
    logic [2:0] idx, ack_idx;
    logic accept, tick, any_zero, all_high, stat_valid, ack_vld;
    stat_t [N_STATS-1:0] st, nxt;
    delta_t [N_STATS-1:0] td;
    logic [N_STATS-1:0] dec;
    logic unused;
    assign unused = ^{bus.action_in[7:6], bus.rand_in[31:5]};
    pet_tick_gen #(.TICK_COUNT(TICK_COUNT)) u_tick (.clk(clk), .rst_n(rst_n), .ena(bus.ena), .tick(tick));
    // prev only holds a real synchronised sample once prime is full, so a button held through reset never fires
    assign edg = s2 & ~prv & {6{prime[2]}};
    assign accept = bus.ena && cd == '0 && |edg;
    assign dec = rand_dec(bus.rand_in[4:0]);
    always_comb begin
        idx = '0;
        for (int i = 5; i >= 0; i--) idx = edg[i] ? 3'(i) : idx;
    end
    always_comb begin
        any_zero = 1'b0;
        all_high = 1'b1;
        for (int i = 0; i < N_STATS; i++) begin
            if (i != S_HEALTH) begin
                any_zero = any_zero | (st[i] == '0);
                all_high = all_high & (st[i] >= 4'd12);
            end
        end
    end
    always_comb begin
        for (int i = 0; i < N_STATS; i++) td[i] = (tick && dec[i]) ? -6'sd1 : 6'sd0;
        td[S_HEALTH] = !tick ? 6'sd0 : any_zero ? -6'sd1 : all_high ? 6'sd1 : 6'sd0;
    end
    always_comb begin
        for (int i = 0; i < N_STATS; i++)
            nxt[i] = apply(st[i], accept ? ACT_DELTA[idx][i] : 6'sd0, td[i],
                           accept && idx == 3'(A_CLEAN) && i == S_HYGIENE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            prv <= '0;
            prime <= '0;
            cd <= '0;
            st <= {N_STATS{INIT_LEVEL}};
            stat_valid <= 1'b0;
            ack_vld <= 1'b0;
            ack_idx <= '0;
        end else begin
            s1 <= bus.action_in[5:0];
            s2 <= s1;
            prv <= s2;
            prime <= {prime[1:0], 1'b1};
            cd <= accept ? CW'(COOLDOWN) : (cd != '0) ? cd - 1'b1 : cd;
            stat_valid <= accept || tick;
            ack_vld <= accept;
            if (accept) ack_idx <= idx;
            if (accept || tick) st <= nxt;
        end
    end
    assign bus.hunger = st[S_HUNGER];
    assign bus.happiness = st[S_HAPPINESS];
    assign bus.health = st[S_HEALTH];
    assign bus.hygiene = st[S_HYGIENE];
    assign bus.energy = st[S_ENERGY];
    assign bus.social = st[S_SOCIAL];
    assign bus.stat_valid = stat_valid;
    assign bus.action_ack = {ack_vld, ack_idx};
endmodule

// File: doc/pet_stats_tracker.md
PET_STATS_TRACKER -- requirements
Module: pet_stats_tracker

Interface
REQ-001 SHALL have parameter TICK_COUNT, default 24'd10_000_000: clk cycles per decay tick.
REQ-002 SHALL have parameter COOLDOWN, default 8: cycles after an accepted action during which new actions are ignored.
REQ-003 SHALL have parameter INIT_LEVEL, default 4'd8: reset value of every stat.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port ena, input, 1: high enables ticking and action acceptance.
REQ-007 SHALL have port action_in, input, 8: raw button levels; bit0 feed, bit1 play, bit2 clean, bit3 sleep, bit4 medicine, bit5 pet; bits 6-7 ignored.
REQ-008 SHALL have port rand_in, input, 32: LFSR word from the random generator, sampled only on tick cycles.
REQ-009 SHALL have ports hunger, happiness, health, hygiene, energy, social, each output, 4: registered wellbeing levels, 15 = best, 0 = critical.
REQ-010 SHALL have port stat_valid, output, 1: one-cycle pulse, registered together with the stats, whenever any stat register is written.
REQ-011 SHALL have port action_ack, output, 4: {valid, action index[2:0]} of the last accepted action; valid is a one-cycle pulse.

Function
REQ-012 SHALL pass action_in[5:0] through a 2-flop synchroniser, then detect rising edges against a registered copy of the synchronised value.
REQ-013 SHALL accept an edge only when ena=1 and the cooldown counter is 0; with several simultaneous edges the lowest bit index wins and the rest are discarded.
REQ-014 SHALL load the cooldown counter with COOLDOWN on acceptance and decrement it to 0 each cycle; edges arriving while it is non-zero are discarded, not queued.
REQ-015 SHALL update the stats on the third rising clk edge after an action_in bit rises (2 sync + 1 update); action_ack.valid and stat_valid assert in that same cycle.
REQ-016 SHALL apply action deltas: feed hunger+4; play happiness+3, social+1, energy-2; clean hygiene set to 15; sleep energy+5; medicine health+4, happiness-1; pet social+3, happiness+1.
REQ-017 SHALL count 0..TICK_COUNT-1 while ena=1 and hold the count while ena=0; the wrap to 0 is the tick cycle.
REQ-018 On a tick, SHALL decrement hunger, happiness, hygiene, energy and social by 1 each when rand_in bits 0, 1, 2, 3 and 4 respectively are 1.
REQ-019 On a tick, SHALL decrement health by 1 if any other stat is 0 before the update; otherwise health SHALL increase by 1 when all other stats are >=12.
REQ-020 SHALL compute each stat as clamp(old + action_delta + tick_delta, 0, 15) in 6-bit signed arithmetic, so a simultaneous action and tick combine in one cycle; clean sets hygiene to 15 and that cycle's hygiene tick_delta is then applied.
REQ-021 SHALL pulse stat_valid on any cycle with an accepted action or a tick, even when clamping leaves the values unchanged.
REQ-022 SHALL hold all stats and suppress stat_valid and action_ack.valid while ena=0; the synchroniser keeps running.

Reset
REQ-023 On rst_n=0, SHALL immediately set all stats to INIT_LEVEL and clear stat_valid, action_ack, the tick counter, the cooldown counter and the synchroniser/edge registers.
REQ-024 SHALL not generate a spurious action when it leaves reset with a button already held; an edge needs a synchronised 0 followed by a 1.
REQ-025 On reset mid-cooldown or mid-tick-period, SHALL discard all progress; the first tick after release SHALL come TICK_COUNT enabled cycles later.

Structure
REQ-026 SHALL place the following in shared package pet_pkg: stat index constants, action bit-index constants, the per-action delta table, STAT_MAX=15 and the 4-bit stat typedef.
REQ-027 SHALL implement the tick counter as sub-module pet_tick_gen (clk, rst_n, ena in; tick out), reusable by the display stage.

Verification
REQ-028 Reset release with TICK_COUNT=4, rand_in=0 -> stats stay 8 and stat_valid pulses every 4 cycles.
REQ-029 action_in[0] rises once -> hunger 8->12 on the 3rd edge, with action_ack=4'b1000 and stat_valid=1 in that cycle; second feed -> 15 (saturates).
REQ-030 Bits 1 and 5 rise in the same cycle -> only play is applied (happiness 11, social 9, energy 6); a pet press within 8 cycles -> ignored.
REQ-031 rand_in=32'h1F, TICK_COUNT=4, no actions -> after 8 ticks the five stats reach 0 and health then decrements on each later tick down to 0 and holds.
REQ-032 A sleep acceptance coinciding with a tick, rand_in bit3=1 -> energy 8->12 (+5-1) in a single cycle.
REQ-033 rst_n pulsed low mid-cooldown while action_in[2] is held -> stats return to 8 and no clean occurs after release until bit2 falls and rises again.
